cmd_proc: RTL and testbench

Command processor sitting directly downstream of the UART command receiver. Consumes each assembled 24-bit command (`cmd`/`cmd_rdy`), acknowledges it with `clr_cmd_rdy`, and executes it against an 8-bit configuration register bus. Returns a 1- or 2-byte response through the UART transmitter's `trmt`/`tx_data`/`tx_done` handshake. Owns no UART timing; it sequences commands and responses only.

---
 rtl/cmd_proc_if.sv | 27 ++
 rtl/cmd_proc.sv | 132 +++++++++++++
 tb/tb_cmd_proc.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_proc_if.sv
// Command/response and configuration-bus bundle between the UART receiver/transmitter,
// the register bank and cmd_proc.
interface cmd_proc_if;
    logic        cmd_rdy;
    logic [23:0] cmd;
    logic        clr_cmd_rdy;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        cfg_wr;
    logic        cfg_rd;
    logic [7:0]  cfg_addr;
    logic [7:0]  cfg_wdata;
    logic [7:0]  cfg_rdata;
    logic        busy;
    logic [7:0]  err_cnt;

    modport master (
        input  cmd_rdy, cmd, tx_done, cfg_rdata,
        output clr_cmd_rdy, trmt, tx_data, cfg_wr, cfg_rd, cfg_addr, cfg_wdata, busy, err_cnt
    );

    modport slave (
        output cmd_rdy, cmd, tx_done, cfg_rdata,
        input  clr_cmd_rdy, trmt, tx_data, cfg_wr, cfg_rd, cfg_addr, cfg_wdata, busy, err_cnt
    );
endinterface

// File: rtl/cmd_proc.sv
// Command processor: consumes 24-bit UART commands, drives the 8-bit config bus
// and returns a 1- or 2-byte response through the UART transmitter handshake.
module cmd_proc #(
    parameter int          TX_TIMEOUT = 4096,
    parameter logic [7:0]  ACK        = 8'hA5,
    parameter logic [7:0]  NAK        = 8'hEE
) (
    input  logic         clk,
    input  logic         rst,
    cmd_proc_if.master   bus
);

    localparam int TW = (TX_TIMEOUT > 2) ? $clog2(TX_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TX_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, DECODE, RD_WAIT, SEND, WAIT} state_t;

    state_t        state;
    logic [23:0]   cmd_q;
    logic [7:0]    resp0;
    logic [7:0]    resp1;
    logic [1:0]    idx;
    logic [1:0]    cnt;
    logic [TW-1:0] tmo;
    logic          tx_prev;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= 2'd0;
            cnt             <= 2'd0;
            tmo             <= '0;
            tx_prev         <= 1'b0;
            bus.clr_cmd_rdy <= 1'b0;
            bus.trmt        <= 1'b0;
            bus.tx_data     <= 8'h00;
            bus.cfg_wr      <= 1'b0;
            bus.cfg_rd      <= 1'b0;
            bus.cfg_addr    <= 8'h00;
            bus.cfg_wdata   <= 8'h00;
            bus.busy        <= 1'b0;
            bus.err_cnt     <= 8'h00;
        end else begin
            // History runs in every state so a level left high outside WAIT is not seen as an edge.
            tx_prev         <= bus.tx_done;
            bus.clr_cmd_rdy <= 1'b0;
            bus.trmt        <= 1'b0;
            bus.cfg_wr      <= 1'b0;
            bus.cfg_rd      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_rdy) begin
                        cmd_q           <= bus.cmd;
                        bus.clr_cmd_rdy <= 1'b1;
                        bus.busy        <= 1'b1;
                        state           <= DECODE;
                    end
                end
                DECODE: begin
                    idx <= 2'd0;
                    case (cmd_q[23:16])
                        8'h01: begin
                            bus.cfg_wr    <= 1'b1;
                            bus.cfg_addr  <= cmd_q[15:8];
                            bus.cfg_wdata <= cmd_q[7:0];
                            resp0         <= ACK;
                            cnt           <= 2'd1;
                            state         <= SEND;
                        end
                        8'h02: begin
                            bus.cfg_rd   <= 1'b1;
                            bus.cfg_addr <= cmd_q[15:8];
                            state        <= RD_WAIT;
                        end
                        8'h03: begin
                            resp0 <= cmd_q[15:8];
                            resp1 <= cmd_q[7:0];
                            cnt   <= 2'd2;
                            state <= SEND;
                        end
                        default: begin
                            resp0       <= NAK;
                            cnt         <= 2'd1;
                            bus.err_cnt <= sat_inc(bus.err_cnt);
                            state       <= SEND;
                        end
                    endcase
                end
                RD_WAIT: begin
                    resp0 <= bus.cfg_rdata;
                    cnt   <= 2'd1;
                    state <= SEND;
                end
                SEND: begin
                    bus.tx_data <= (idx == 2'd0) ? resp0 : resp1;
                    bus.trmt    <= 1'b1;
                    tmo         <= '0;
                    state       <= WAIT;
                end
                WAIT: begin
                    if (bus.tx_done && !tx_prev) begin
                        if (idx + 2'd1 == cnt) begin
                            idx      <= 2'd0;
                            bus.busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= SEND;
                        end
                    end else if (tmo == TMO_LAST) begin
                        // Unsent bytes of this response are dropped on timeout.
                        idx         <= 2'd0;
                        bus.busy    <= 1'b0;
                        bus.err_cnt <= sat_inc(bus.err_cnt);
                        state       <= IDLE;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_proc.sv
// Directed bench for cmd_proc: WRITE, READ, ECHO, NAK, timeout, queued command and reset mid-WAIT.
module tb_cmd_proc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   n_clr = 0, n_trmt = 0, n_wr = 0, n_rd = 0;
    int   b_clr, b_trmt, b_wr, b_rd;
    int   k;

    cmd_proc_if bus();

    cmd_proc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Pulse counters sample the values registered at the previous edge.
    always @(posedge clk) begin
        if (bus.clr_cmd_rdy) n_clr++;
        if (bus.trmt)        n_trmt++;
        if (bus.cfg_wr)      n_wr++;
        if (bus.cfg_rd)      n_rd++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_clr = n_clr; b_trmt = n_trmt; b_wr = n_wr; b_rd = n_rd;
    endtask

    initial begin
        bus.cmd_rdy   = 1'b0;
        bus.cmd       = 24'h0;
        bus.tx_done   = 1'b0;
        bus.cfg_rdata = 8'h00;
        step(2);
        chk("rst_busy",    32'(bus.busy), 32'd0);
        chk("rst_trmt",    32'(bus.trmt), 32'd0);
        chk("rst_clr",     32'(bus.clr_cmd_rdy), 32'd0);
        chk("rst_txdata",  32'(bus.tx_data), 32'h00);
        chk("rst_errcnt",  32'(bus.err_cnt), 32'h00);
        chk("rst_addr",    32'(bus.cfg_addr), 32'h00);
        rst = 1'b0;
        step(1);

        // WRITE 011234
        snap();
        bus.cmd = 24'h011234; bus.cmd_rdy = 1'b1;
        step(1);
        chk("wr_clr",  32'(bus.clr_cmd_rdy), 32'd1);
        chk("wr_busy", 32'(bus.busy), 32'd1);
        bus.cmd_rdy = 1'b0; bus.cmd = 24'hFFFFFF;
        step(1);
        chk("wr_strobe", 32'(bus.cfg_wr), 32'd1);
        chk("wr_addr",   32'(bus.cfg_addr), 32'h12);
        chk("wr_wdata",  32'(bus.cfg_wdata), 32'h34);
        step(1);
        chk("wr_trmt",   32'(bus.trmt), 32'd1);
        chk("wr_ack",    32'(bus.tx_data), 32'hA5);
        step(3);
        chk("wr_busy_hold", 32'(bus.busy), 32'd1);
        bus.tx_done = 1'b1;
        step(1);
        chk("wr_busy_done", 32'(bus.busy), 32'd0);
        bus.tx_done = 1'b0;
        step(2);
        chk("wr_n_clr",  32'(n_clr - b_clr), 32'd1);
        chk("wr_n_wr",   32'(n_wr - b_wr), 32'd1);
        chk("wr_n_trmt", 32'(n_trmt - b_trmt), 32'd1);

        // READ 020700 with rdata 5C
        snap();
        bus.cmd = 24'h020700; bus.cmd_rdy = 1'b1; bus.cfg_rdata = 8'h5C;
        step(1);
        chk("rd_clr", 32'(bus.clr_cmd_rdy), 32'd1);
        bus.cmd_rdy = 1'b0;
        step(1);
        chk("rd_strobe", 32'(bus.cfg_rd), 32'd1);
        chk("rd_addr",   32'(bus.cfg_addr), 32'h07);
        step(1);
        chk("rd_no_trmt_yet", 32'(bus.trmt), 32'd0);
        step(1);
        chk("rd_trmt", 32'(bus.trmt), 32'd1);
        chk("rd_data", 32'(bus.tx_data), 32'h5C);
        bus.cfg_rdata = 8'h00;
        step(2);
        bus.tx_done = 1'b1;
        step(1);
        chk("rd_busy_done", 32'(bus.busy), 32'd0);
        bus.tx_done = 1'b0;
        step(2);
        chk("rd_n_rd",   32'(n_rd - b_rd), 32'd1);
        chk("rd_n_trmt", 32'(n_trmt - b_trmt), 32'd1);

        // ECHO 03BEEF
        snap();
        bus.cmd = 24'h03BEEF; bus.cmd_rdy = 1'b1;
        step(1);
        bus.cmd_rdy = 1'b0;
        step(2);
        chk("echo_trmt0", 32'(bus.trmt), 32'd1);
        chk("echo_byte0", 32'(bus.tx_data), 32'hBE);
        step(3);
        chk("echo_wait_edge", 32'(n_trmt - b_trmt), 32'd1);
        bus.tx_done = 1'b1;
        step(1);
        chk("echo_gap", 32'(bus.trmt), 32'd0);
        step(1);
        chk("echo_trmt1", 32'(bus.trmt), 32'd1);
        chk("echo_byte1", 32'(bus.tx_data), 32'hEF);
        bus.tx_done = 1'b0;
        step(2);
        chk("echo_busy_mid", 32'(bus.busy), 32'd1);
        bus.tx_done = 1'b1;
        step(1);
        chk("echo_busy_done", 32'(bus.busy), 32'd0);
        chk("echo_hold", 32'(bus.tx_data), 32'hEF);
        bus.tx_done = 1'b0;
        step(2);

        // Unknown opcode 7F
        snap();
        bus.cmd = 24'h7F0102; bus.cmd_rdy = 1'b1;
        step(1);
        bus.cmd_rdy = 1'b0;
        step(1);
        chk("nak_no_wr", 32'(bus.cfg_wr), 32'd0);
        chk("nak_no_rd", 32'(bus.cfg_rd), 32'd0);
        step(1);
        chk("nak_trmt", 32'(bus.trmt), 32'd1);
        chk("nak_data", 32'(bus.tx_data), 32'hEE);
        chk("nak_err",  32'(bus.err_cnt), 32'd1);
        bus.tx_done = 1'b1;
        step(1);
        bus.tx_done = 1'b0;
        step(2);
        chk("nak_busy", 32'(bus.busy), 32'd0);
        chk("nak_n_strobe", 32'((n_wr - b_wr) + (n_rd - b_rd)), 32'd0);

        // Timeout: tx_done never rises
        bus.cmd = 24'h01AA55; bus.cmd_rdy = 1'b1;
        step(1);
        bus.cmd_rdy = 1'b0;
        step(2);
        chk("tmo_trmt", 32'(bus.trmt), 32'd1);
        k = 0;
        while (bus.busy && k < 5000) begin
            step(1);
            k++;
        end
        chk("tmo_cycles", 32'(k), 32'd4096);
        chk("tmo_err",    32'(bus.err_cnt), 32'd2);
        step(1);
        bus.cmd = 24'h014321; bus.cmd_rdy = 1'b1;
        step(1);
        bus.cmd_rdy = 1'b0;
        step(1);
        chk("post_tmo_addr", 32'(bus.cfg_addr), 32'h43);
        step(1);
        chk("post_tmo_ack", 32'(bus.tx_data), 32'hA5);
        bus.tx_done = 1'b1;
        step(1);
        chk("post_tmo_busy", 32'(bus.busy), 32'd0);
        chk("post_tmo_err",  32'(bus.err_cnt), 32'd2);
        bus.tx_done = 1'b0;
        step(2);

        // Second command queued during ECHO
        snap();
        bus.cmd = 24'h03BEEF; bus.cmd_rdy = 1'b1;
        step(1);
        bus.cmd = 24'h015678;
        step(1);
        step(1);
        chk("q_byte0", 32'(bus.tx_data), 32'hBE);
        bus.tx_done = 1'b1;
        step(2);
        chk("q_byte1", 32'(bus.tx_data), 32'hEF);
        bus.tx_done = 1'b0;
        step(1);
        chk("q_not_consumed", 32'(n_clr - b_clr), 32'd1);
        bus.tx_done = 1'b1;
        step(1);
        chk("q_busy_low", 32'(bus.busy), 32'd0);
        step(1);
        chk("q_clr2", 32'(bus.clr_cmd_rdy), 32'd1);
        bus.cmd_rdy = 1'b0; bus.tx_done = 1'b0;
        step(1);
        chk("q_addr", 32'(bus.cfg_addr), 32'h56);
        chk("q_wdata", 32'(bus.cfg_wdata), 32'h78);
        step(1);
        chk("q_ack", 32'(bus.tx_data), 32'hA5);
        step(2);

        // Reset while waiting for tx_done, with a new command pending
        bus.cmd = 24'h03C3D4; bus.cmd_rdy = 1'b1; rst = 1'b1;
        step(1);
        chk("mr_busy",   32'(bus.busy), 32'd0);
        chk("mr_txdata", 32'(bus.tx_data), 32'h00);
        chk("mr_err",    32'(bus.err_cnt), 32'h00);
        chk("mr_addr",   32'(bus.cfg_addr), 32'h00);
        chk("mr_clr",    32'(bus.clr_cmd_rdy), 32'd0);
        step(1);
        rst = 1'b0;
        step(1);
        chk("mr_reclr", 32'(bus.clr_cmd_rdy), 32'd1);
        bus.cmd_rdy = 1'b0;
        step(2);
        chk("mr_trmt0", 32'(bus.trmt), 32'd1);
        chk("mr_byte0", 32'(bus.tx_data), 32'hC3);
        bus.tx_done = 1'b1;
        step(2);
        chk("mr_byte1", 32'(bus.tx_data), 32'hD4);
        bus.tx_done = 1'b0;
        step(1);
        bus.tx_done = 1'b1;
        step(1);
        chk("mr_busy_done", 32'(bus.busy), 32'd0);
        bus.tx_done = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
